sram_banked_macro_array: RTL

//  Parametrised single-port SRAM array built from ARM_SPSRAM_64X4096_M8_MEM macros: WIDTH/64 column

---
 rtl/sram_banked_macro_array.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_banked_macro_array.sv
// Banked single-port SRAM array built from 64x4096 macros, with req/gnt/rvalid port,
// byte-enable writes, per-bank chip-enable gating, optional output register and zero-fill.
module sram_banked_macro_array #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned DEPTH     = 8192,
    parameter int unsigned OUT_REG   = 0,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ,
    output logic                     GNT,
    input  logic                     WE,
    input  logic [WIDTH/8-1:0]       BE,
    input  logic [$clog2(DEPTH)-1:0] A,
    input  logic [WIDTH-1:0]         D,
    output logic [WIDTH-1:0]         Q,
    output logic                     RVALID,
    input  logic [2:0]               EMA,
    input  logic [1:0]               EMAW,
    output logic                     INIT_DONE
);

    localparam int unsigned NCOL  = WIDTH / 64;
    localparam int unsigned NBANK = DEPTH / 4096;
    localparam int unsigned BW    = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int unsigned NBE   = WIDTH / 8;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] row_cnt_q, row_cnt_d;
    logic        init_done_q, init_done_d;
    logic        rd_vld_q;
    logic        rd_zero_q;
    logic [BW-1:0] rd_bank_q;

    logic [31:0]      bank_full;
    logic             addr_ok;
    logic [BW-1:0]    bank_idx;
    logic             acc_rd, acc_wr;
    logic [WIDTH-1:0] be_mask;

    logic [NBANK-1:0]             bank_cen;
    logic                         m_gwen;
    logic [WIDTH-1:0]             m_wen;
    logic [11:0]                  m_a;
    logic [WIDTH-1:0]             m_d;
    logic [NBANK-1:0][WIDTH-1:0]  bank_q;
    logic [WIDTH-1:0]             rd_data_c;

    assign GNT       = init_done_q;
    assign INIT_DONE = init_done_q;

    // Bank index from address bits above the 4096-row macro depth.
    assign bank_full = 32'(A) >> 12;
    assign addr_ok   = bank_full < 32'(NBANK);
    assign bank_idx  = BW'(bank_full);
    assign acc_rd    = REQ && GNT && !WE;
    assign acc_wr    = REQ && GNT && WE && addr_ok && (|BE);

    always_comb begin
        be_mask = '1;
        for (int unsigned i = 0; i < NBE; i++) begin
            be_mask[i*8 +: 8] = {8{~BE[i]}};
        end
    end

    // Next state and macro controls; only the addressed bank is enabled in IDLE.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        init_done_d = init_done_q;
        bank_cen    = '1;
        m_gwen      = 1'b1;
        m_wen       = '1;
        m_a         = A[11:0];
        m_d         = D;
        if (!RST) begin
            case (state_q)
                ST_INIT: begin
                    bank_cen  = '0;
                    m_gwen    = 1'b0;
                    m_wen     = '0;
                    m_a       = row_cnt_q;
                    m_d       = '0;
                    row_cnt_d = 12'(row_cnt_q + 12'd1);
                    if (row_cnt_q == 12'hFFF) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end
                end
                default: begin
                    init_done_d = 1'b1;
                    if (acc_wr) begin
                        bank_cen[bank_idx] = 1'b0;
                        m_gwen             = 1'b0;
                        m_wen              = be_mask;
                    end else if (acc_rd && addr_ok) begin
                        bank_cen[bank_idx] = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
            row_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_zero_q   <= 1'b1;
            rd_bank_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            init_done_q <= init_done_d;
            rd_vld_q    <= acc_rd;
            if (acc_rd) begin
                rd_bank_q <= bank_idx;
                rd_zero_q <= !addr_ok;
            end
        end
    end

    // Macros hold their last read word, so the registered bank select keeps Q stable.
    assign rd_data_c = rd_zero_q ? '0 : bank_q[rd_bank_q];

    if (OUT_REG != 0) begin : g_oreg
        logic             rv2_q;
        logic [WIDTH-1:0] q_q;
        always_ff @(posedge CLK) begin
            if (RST) begin
                rv2_q <= 1'b0;
                q_q   <= '0;
            end else begin
                rv2_q <= rd_vld_q;
                if (rd_vld_q) begin
                    q_q <= rd_data_c;
                end
            end
        end
        assign RVALID = rv2_q;
        assign Q      = q_q;
    end else begin : g_nreg
        assign RVALID = rd_vld_q;
        assign Q      = rd_data_c;
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        for (genvar c = 0; c < NCOL; c++) begin : g_col
            ARM_SPSRAM_64X4096_M8_MEM u_mem (
                .CLK   (CLK),
                .CEN   (bank_cen[b]),
                .GWEN  (m_gwen),
                .WEN   (m_wen[c*64 +: 64]),
                .A     (m_a),
                .D     (m_d[c*64 +: 64]),
                .Q     (bank_q[b][c*64 +: 64]),
                .EMA   (EMA),
                .EMAW  (EMAW),
                .EMAS  (1'b0),
                .RET1N (1'b1)
            );
        end
    end

endmodule

// Behavioral stand-in for the 64x4096 single-port macro: active-low CEN/GWEN/WEN,
// Q updated only by reads and held otherwise.
module ARM_SPSRAM_64X4096_M8_MEM (
    input  logic        CLK,
    input  logic        CEN,
    input  logic        GWEN,
    input  logic [63:0] WEN,
    input  logic [11:0] A,
    input  logic [63:0] D,
    output logic [63:0] Q,
    input  logic [2:0]  EMA,
    input  logic [1:0]  EMAW,
    input  logic        EMAS,
    input  logic        RET1N
);

    logic [63:0] mem [4096];
    logic        unused_pins;

    assign unused_pins = ^{EMA, EMAW, EMAS, RET1N};

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                mem[A] <= (mem[A] & WEN) | (D & ~WEN);
            end else begin
                Q <= mem[A];
            end
        end
    end

endmodule
